prga_decrypt: RTL and testbench

//  RC4 keystream generator/decryptor; the consumer of the S-box that ksa builds.

---
 rtl/prga_pkg.sv | 30 +++
 rtl/prga_decrypt_if.sv | 49 ++++
 rtl/prga_decrypt.sv | 145 ++++++++++++++
 tb/tb_prga_decrypt.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prga_pkg.sv
// Shared definitions for the RC4 keystream generator / decryptor.
//   AW, DW  : default address/data width of the S, ct and pt memories.
//   state_t : controller states.
package prga_pkg;

    localparam int AW = 8;
    localparam int DW = 8;

    typedef enum logic [4:0] {
        IDLE,
        RDL1,
        RDL2,
        WRL,
        INCI,
        RDI1,
        RDI2,
        CALCJ,
        RDJ1,
        RDJ2,
        WRI,
        WRJ,
        RDK1,
        RDK2,
        RDC1,
        RDC2,
        WRP,
        DONE
    } state_t;

endpackage

// File: rtl/prga_decrypt_if.sv
// Bus bundle of prga_decrypt: en/rdy handshake plus the S memory
// (read/write), ciphertext memory (read-only) and plaintext memory
// (write-only) ports.
//   master : the decryptor (drives rdy, addresses, write data, enables)
//   slave  : the environment (drives en and memory read data)
interface prga_decrypt_if;
    import prga_pkg::*;

    logic          en;
    logic          rdy;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_rddata;
    logic [DW-1:0] s_wrdata;
    logic          s_wren;
    logic [AW-1:0] ct_addr;
    logic [DW-1:0] ct_rddata;
    logic [AW-1:0] pt_addr;
    logic [DW-1:0] pt_wrdata;
    logic          pt_wren;

    modport master (
        input  en,
        output rdy,
        output s_addr,
        input  s_rddata,
        output s_wrdata,
        output s_wren,
        output ct_addr,
        input  ct_rddata,
        output pt_addr,
        output pt_wrdata,
        output pt_wren
    );

    modport slave (
        output en,
        input  rdy,
        input  s_addr,
        output s_rddata,
        input  s_wrdata,
        input  s_wren,
        input  ct_addr,
        output ct_rddata,
        input  pt_addr,
        input  pt_wrdata,
        input  pt_wren
    );

endinterface

// File: rtl/prga_decrypt.sv
// RC4 PRGA keystream generator and decryptor.
// Reads the S-box left in S memory by the key scheduler, runs the PRGA
// swap loop (writing S back), and XORs the keystream with a length-prefixed
// ciphertext to produce a length-prefixed plaintext.
// Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-high reset
//   bus  : prga_decrypt_if.master (en/rdy handshake, S/ct/pt memory ports)
// Every memory read holds its address for two cycles and captures read data
// at the end of the second one, so both combinational and registered RAMs
// work. All outputs are registered: each output register is loaded on the
// edge that enters the state which needs it.
module prga_decrypt
    import prga_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    prga_decrypt_if.master bus
);

    state_t present_state;
    state_t next_state;

    logic [AW-1:0] i;
    logic [AW-1:0] j;
    logic [AW-1:0] k;
    logic [DW-1:0] len;
    logic [DW-1:0] si;
    logic [DW-1:0] sj;
    logic [DW-1:0] pad;

    always_ff @(posedge clk) begin
        if (rst) present_state <= IDLE;
        else     present_state <= next_state;
    end

    always_comb begin
        next_state = present_state;
        case (present_state)
            IDLE:    if (bus.en) next_state = RDL1;
            RDL1:    next_state = RDL2;
            RDL2:    next_state = WRL;
            WRL:     next_state = (len == '0) ? DONE : INCI;
            INCI:    next_state = RDI1;
            RDI1:    next_state = RDI2;
            RDI2:    next_state = CALCJ;
            CALCJ:   next_state = RDJ1;
            RDJ1:    next_state = RDJ2;
            RDJ2:    next_state = WRI;
            WRI:     next_state = WRJ;
            WRJ:     next_state = RDK1;
            RDK1:    next_state = RDK2;
            RDK2:    next_state = RDC1;
            RDC1:    next_state = RDC2;
            RDC2:    next_state = WRP;
            WRP:     next_state = (k < len) ? INCI : DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rdy       <= 1'b1;
            bus.s_addr    <= '0;
            bus.s_wrdata  <= '0;
            bus.s_wren    <= 1'b0;
            bus.ct_addr   <= '0;
            bus.pt_addr   <= '0;
            bus.pt_wrdata <= '0;
            bus.pt_wren   <= 1'b0;
            i             <= '0;
            j             <= '0;
            k             <= '0;
            len           <= '0;
            si            <= '0;
            sj            <= '0;
            pad           <= '0;
        end else begin
            // Write enables are single-cycle pulses; addresses and data hold.
            bus.s_wren  <= 1'b0;
            bus.pt_wren <= 1'b0;
            case (present_state)
                IDLE: begin
                    if (bus.en) begin
                        bus.rdy     <= 1'b0;
                        bus.ct_addr <= '0;
                        i           <= '0;
                        j           <= '0;
                        k           <= '0;
                    end
                end
                RDL2: begin
                    // Length goes straight to pt[0] during WRL.
                    len           <= bus.ct_rddata;
                    bus.pt_addr   <= '0;
                    bus.pt_wrdata <= bus.ct_rddata;
                    bus.pt_wren   <= 1'b1;
                end
                INCI: begin
                    i          <= i + 1'b1;
                    k          <= k + 1'b1;
                    bus.s_addr <= i + 1'b1;
                end
                RDI2: begin
                    si <= bus.s_rddata;
                end
                CALCJ: begin
                    j          <= j + si;
                    bus.s_addr <= j + si;
                end
                RDJ2: begin
                    // S[i] <= sj. si and sj are both captured before either
                    // write, so i == j degenerates to two identical writes.
                    sj           <= bus.s_rddata;
                    bus.s_addr   <= i;
                    bus.s_wrdata <= bus.s_rddata;
                    bus.s_wren   <= 1'b1;
                end
                WRI: begin
                    bus.s_addr   <= j;
                    bus.s_wrdata <= si;
                    bus.s_wren   <= 1'b1;
                end
                WRJ: begin
                    bus.s_addr <= si + sj;
                end
                RDK2: begin
                    pad         <= bus.s_rddata;
                    bus.ct_addr <= k;
                end
                RDC2: begin
                    bus.pt_addr   <= k;
                    bus.pt_wrdata <= pad ^ bus.ct_rddata;
                    bus.pt_wren   <= 1'b1;
                end
                DONE: begin
                    bus.rdy <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prga_decrypt.sv
// Directed self-checking bench for prga_decrypt. Memories are modelled here
// with registered (1-cycle) reads. Expected values are hand-derived constants
// or come from a behavioural RC4 (KSA + PRGA) model inside the bench.
module tb_prga_decrypt;
    import prga_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prga_decrypt_if bus();

    prga_decrypt dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory models
    logic [7:0] s_mem  [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] s_rd_q  = 8'h00;
    logic [7:0] ct_rd_q = 8'h00;
    int         s_wr_cnt  = 0;
    int         pt_wr_cnt = 0;

    // Bench-side loader into S/pt memories
    logic       ld_en    = 1'b0;
    logic [7:0] ld_addr  = 8'h00;
    logic [7:0] ld_sdata = 8'h00;

    assign bus.s_rddata  = s_rd_q;
    assign bus.ct_rddata = ct_rd_q;

    always @(posedge clk) begin
        s_rd_q  <= s_mem[bus.s_addr];
        ct_rd_q <= ct_mem[bus.ct_addr];
        if (bus.s_wren) begin
            s_mem[bus.s_addr] <= bus.s_wrdata;
            s_wr_cnt <= s_wr_cnt + 1;
        end else if (ld_en) begin
            s_mem[ld_addr] <= ld_sdata;
        end
        if (bus.pt_wren) begin
            pt_mem[bus.pt_addr] <= bus.pt_wrdata;
            pt_wr_cnt <= pt_wr_cnt + 1;
        end else if (ld_en) begin
            pt_mem[ld_addr] <= 8'hFF;
        end
    end

    // Reference model state
    logic [7:0] m_s  [256];
    logic [7:0] m_pt [256];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_identity();
        for (int a = 0; a < 256; a++) m_s[a] = 8'(a);
    endtask

    // Copy m_s into S memory and fill pt memory with FF.
    task automatic prep();
        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            ld_en    = 1'b1;
            ld_addr  = 8'(a);
            ld_sdata = m_s[a];
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic ksa_model(input logic [23:0] key);
        logic [7:0] kb [3];
        logic [7:0] jj;
        logic [7:0] t;
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        set_identity();
        jj = 8'h00;
        for (int a = 0; a < 256; a++) begin
            jj = jj + m_s[a] + kb[a % 3];
            t = m_s[a];
            m_s[a] = m_s[jj];
            m_s[jj] = t;
        end
    endtask

    // PRGA over m_s (in place) and ct_mem, producing m_pt.
    task automatic prga_model();
        logic [7:0] ii, jj, si, sj, ln;
        ii = 8'h00;
        jj = 8'h00;
        ln = ct_mem[0];
        m_pt[0] = ln;
        for (int kk = 1; kk <= int'(ln); kk++) begin
            ii = ii + 8'h01;
            si = m_s[ii];
            jj = jj + si;
            sj = m_s[jj];
            m_s[ii] = sj;
            m_s[jj] = si;
            m_pt[kk] = m_s[8'(si + sj)] ^ ct_mem[kk];
        end
    endtask

    // Cycle count includes the cycle in which en is presented; returns when
    // rdy is seen high (bounded). poke>0 re-asserts en for one cycle mid-run.
    task automatic run(input int poke, output int cyc);
        @(negedge clk);
        bus.en = 1'b1;
        @(posedge clk);
        #1 bus.en = 1'b0;
        cyc = 1;
        while (bus.rdy !== 1'b1 && cyc < 20000) begin
            if (cyc == poke) bus.en = 1'b1;
            @(posedge clk);
            #1 bus.en = 1'b0;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int s0, p0;
        logic [7:0] exp_s;

        bus.en = 1'b0;
        for (int a = 0; a < 256; a++) begin
            s_mem[a]  = 8'(a);
            ct_mem[a] = 8'h00;
            pt_mem[a] = 8'hFF;
        end

        // 1: reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_rdy",       32'(bus.rdy),       32'd1);
        chk("rst_s_wren",    32'(bus.s_wren),    32'd0);
        chk("rst_pt_wren",   32'(bus.pt_wren),   32'd0);
        chk("rst_state",     32'(dut.present_state), 32'(IDLE));
        chk("rst_s_addr",    32'(bus.s_addr),    32'd0);
        chk("rst_ct_addr",   32'(bus.ct_addr),   32'd0);
        chk("rst_pt_addr",   32'(bus.pt_addr),   32'd0);
        chk("rst_s_wrdata",  32'(bus.s_wrdata),  32'd0);
        chk("rst_pt_wrdata", 32'(bus.pt_wrdata), 32'd0);

        // 2: identity S, one byte
        set_identity();
        ct_mem[0] = 8'd1;
        ct_mem[1] = 8'h41;
        prep();
        run(0, cyc);
        chk("l1_latency", 32'(cyc), 32'd18);
        chk("l1_pt0", 32'(pt_mem[0]), 32'd1);
        chk("l1_pt1", 32'(pt_mem[1]), 32'h43);

        // 3: identity S, two bytes, S swap at 2/3
        set_identity();
        ct_mem[0] = 8'd2;
        ct_mem[1] = 8'h41;
        ct_mem[2] = 8'h00;
        prep();
        run(0, cyc);
        chk("l2_latency", 32'(cyc), 32'd31);
        chk("l2_pt0", 32'(pt_mem[0]), 32'd2);
        chk("l2_pt1", 32'(pt_mem[1]), 32'h43);
        chk("l2_pt2", 32'(pt_mem[2]), 32'h05);
        for (int a = 0; a < 256; a++) begin
            exp_s = (a == 2) ? 8'd3 : (a == 3) ? 8'd2 : 8'(a);
            chk($sformatf("l2_s[%0d]", a), 32'(s_mem[a]), 32'(exp_s));
        end

        // 4: zero length
        set_identity();
        ct_mem[0] = 8'd0;
        prep();
        s0 = s_wr_cnt;
        p0 = pt_wr_cnt;
        run(0, cyc);
        chk("l0_latency", 32'(cyc), 32'd5);
        chk("l0_pt_writes", 32'(pt_wr_cnt - p0), 32'd1);
        chk("l0_s_writes", 32'(s_wr_cnt - s0), 32'd0);
        chk("l0_pt0", 32'(pt_mem[0]), 32'd0);

        // 5: KSA-derived S, 255-byte ciphertext, against the RC4 model
        ksa_model(24'h00033C);
        ct_mem[0] = 8'd255;
        for (int a = 1; a < 256; a++) ct_mem[a] = 8'($urandom_range(0, 255));
        prep();
        prga_model();
        run(0, cyc);
        chk("l255_latency", 32'(cyc), 32'd3320);
        for (int a = 0; a < 256; a++)
            chk($sformatf("l255_pt[%0d]", a), 32'(pt_mem[a]), 32'(m_pt[a]));
        for (int a = 0; a < 256; a++)
            chk($sformatf("l255_s[%0d]", a), 32'(s_mem[a]), 32'(m_s[a]));

        // 6a: en pulsed mid-run has no effect
        set_identity();
        ct_mem[0] = 8'd10;
        for (int a = 1; a <= 10; a++) ct_mem[a] = 8'($urandom_range(0, 255));
        prep();
        prga_model();
        run(40, cyc);
        chk("poke_latency", 32'(cyc), 32'd135);
        for (int a = 0; a <= 10; a++)
            chk($sformatf("poke_pt[%0d]", a), 32'(pt_mem[a]), 32'(m_pt[a]));

        // 6b: reset during byte 3 of 10
        set_identity();
        prep();
        p0 = pt_wr_cnt;
        @(negedge clk);
        bus.en = 1'b1;
        @(posedge clk);
        #1 bus.en = 1'b0;
        cyc = 0;
        while (pt_wr_cnt - p0 < 3 && cyc < 2000) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("abort_reach_byte3", 32'(cyc < 2000), 32'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_state", 32'(dut.present_state), 32'(IDLE));
        chk("abort_rdy", 32'(bus.rdy), 32'd1);
        chk("abort_s_wren", 32'(bus.s_wren), 32'd0);
        chk("abort_pt_wren", 32'(bus.pt_wren), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        s0 = s_wr_cnt;
        p0 = pt_wr_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_quiet_s", 32'(s_wr_cnt - s0), 32'd0);
        chk("abort_quiet_pt", 32'(pt_wr_cnt - p0), 32'd0);
        chk("abort_idle_rdy", 32'(bus.rdy), 32'd1);

        // restart after reset
        set_identity();
        ct_mem[0] = 8'd1;
        ct_mem[1] = 8'h41;
        prep();
        run(0, cyc);
        chk("restart_latency", 32'(cyc), 32'd18);
        chk("restart_pt0", 32'(pt_mem[0]), 32'd1);
        chk("restart_pt1", 32'(pt_mem[1]), 32'h43);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
